// File: rtl/scratch_pad_port_arbiter_pkg.sv
// Shared types and width helpers for the scratch_pad port arbiter slice.
package scratch_pad_port_arbiter_pkg;

    // Kind of access issued to the scratch_pad in a given cycle.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } sp_op_e;

    // Floor of log2; log2_floor(1) is 0.
    function automatic int log2_floor(input int n);
        int v;
        int r;
        v = n;
        r = 0;
        while (v > 1) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Width needed to index a requester: log2(n-1)+1.
    function automatic int id_width(input int requesters);
        return log2_floor(requesters - 1) + 1;
    endfunction

    // Width of a counter able to hold the value depth itself.
    function automatic int count_width(input int depth);
        return log2_floor(depth) + 1;
    endfunction

endpackage

// File: rtl/scratch_pad_port_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for reads in flight; the head names the
// requester that owns the next scratch_pad read return.
module scratch_pad_port_arbiter_id_fifo
    import scratch_pad_port_arbiter_pkg::*;
#(
    parameter int ID_WIDTH = 2,
    parameter int DEPTH    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [ID_WIDTH-1:0] push_id,
    input  logic                pop,
    output logic [ID_WIDTH-1:0] head_id,
    output logic                empty,
    output logic                full
);

    localparam int PTR_W = id_width(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [ID_WIDTH-1:0] mem_q [DEPTH];
    logic [ID_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                push_ok_s;
    logic                pop_ok_s;

    // Status flags and head entry straight from the registered state.
    always_comb begin
        empty   = (cnt_q == CNT_W'(0));
        full    = (cnt_q == CNT_W'(DEPTH));
        head_id = mem_q[rd_ptr_q];
    end

    // Next-state for storage, pointers and fill count; overflow/underflow are ignored.
    always_comb begin
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;

        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_id;
            if (wr_ptr_q == PTR_W'(DEPTH - 1)) begin
                wr_ptr_d = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_ok_s) begin
            if (rd_ptr_q == PTR_W'(DEPTH - 1)) begin
                rd_ptr_d = '0;
            end else begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/scratch_pad_port_arbiter.sv
// Round-robin arbiter sharing one scratch_pad port between several clients.
// Grants respect scratch_pad backpressure and an outstanding-read budget;
// read returns are routed back to their issuer through an in-order ID FIFO.
module scratch_pad_port_arbiter
    import scratch_pad_port_arbiter_pkg::*;
#(
    parameter int REQUESTERS      = 4,
    parameter int WIDTH           = 64,
    parameter int ADDR_WIDTH      = 12,
    parameter int MAX_OUTSTANDING = 32,
    parameter int ID_WIDTH        = id_width(REQUESTERS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [0:REQUESTERS-1]            req_rd_en,
    input  logic [0:REQUESTERS-1]            req_wr_en,
    input  logic [ADDR_WIDTH*REQUESTERS-1:0] req_addr,
    input  logic [WIDTH*REQUESTERS-1:0]      req_d,
    output logic [0:REQUESTERS-1]            req_grant,
    output logic [WIDTH-1:0]                 req_q,
    output logic [0:REQUESTERS-1]            req_valid,
    input  logic [0:REQUESTERS-1]            req_stall,
    output logic                             sp_rd_en,
    output logic                             sp_wr_en,
    output logic [ADDR_WIDTH-1:0]            sp_addr,
    output logic [WIDTH-1:0]                 sp_d,
    input  logic                             sp_full,
    input  logic [WIDTH-1:0]                 sp_q,
    input  logic                             sp_valid,
    output logic                             sp_stall
);

    localparam int CNT_W = count_width(MAX_OUTSTANDING);

    // Registered state
    logic [ID_WIDTH-1:0]   rr_ptr_q;
    logic [ID_WIDTH-1:0]   rr_ptr_d;
    logic [CNT_W-1:0]      outstanding_q;
    logic [CNT_W-1:0]      outstanding_d;
    logic                  sp_rd_en_q;
    logic                  sp_rd_en_d;
    logic                  sp_wr_en_q;
    logic                  sp_wr_en_d;
    logic [ADDR_WIDTH-1:0] sp_addr_q;
    logic [ADDR_WIDTH-1:0] sp_addr_d;
    logic [WIDTH-1:0]      sp_d_q;
    logic [WIDTH-1:0]      sp_d_d;
    logic [0:REQUESTERS-1] req_valid_q;
    logic [0:REQUESTERS-1] req_valid_d;
    logic [WIDTH-1:0]      req_q_q;
    logic [WIDTH-1:0]      req_q_d;

    // Combinational helpers
    logic [ADDR_WIDTH-1:0] addr_arr_s [REQUESTERS];
    logic [WIDTH-1:0]      data_arr_s [REQUESTERS];
    logic [0:REQUESTERS-1] elig_s;
    logic [0:REQUESTERS-1] grant_s;
    logic                  rd_budget_ok_s;
    logic                  found_s;
    logic [ID_WIDTH-1:0]   win_s;
    logic [ID_WIDTH-1:0]   idx_s;
    sp_op_e                op_s;
    logic                  push_s;
    logic                  pop_s;
    logic [ID_WIDTH-1:0]   head_id_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;

    // Unpack the flat request buses; requester 0 sits in the MSBs.
    always_comb begin
        for (int i = 0; i < REQUESTERS; i++) begin
            addr_arr_s[i] = req_addr[(REQUESTERS-1-i)*ADDR_WIDTH +: ADDR_WIDTH];
            data_arr_s[i] = req_d[(REQUESTERS-1-i)*WIDTH +: WIDTH];
        end
    end

    // Eligibility: writes always count, reads only while the budget has room.
    always_comb begin
        rd_budget_ok_s = (outstanding_q < CNT_W'(MAX_OUTSTANDING)) & ~fifo_full_s;
        for (int i = 0; i < REQUESTERS; i++) begin
            elig_s[i] = rst & ~sp_full & (req_wr_en[i] | (req_rd_en[i] & rd_budget_ok_s));
        end
    end

    // Round-robin search starting at rr_ptr; wrap comes free from the ID width.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            idx_s = rr_ptr_q + ID_WIDTH'(k);
            if (!found_s && elig_s[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Decode the winner into a one-hot grant and the operation kind; a
    // simultaneous read and write from one requester is treated as a write.
    always_comb begin
        grant_s = '0;
        op_s    = OP_IDLE;
        if (found_s) begin
            grant_s[win_s] = 1'b1;
            if (req_wr_en[win_s]) begin
                op_s = OP_WRITE;
            end else begin
                op_s = OP_READ;
            end
        end else begin
            op_s = OP_IDLE;
        end
        req_grant = grant_s;
    end

    // Next values for the issue register, pointer and read budget.
    always_comb begin
        sp_rd_en_d = 1'b0;
        sp_wr_en_d = 1'b0;
        sp_addr_d  = sp_addr_q;
        sp_d_d     = sp_d_q;
        case (op_s)
            OP_READ: begin
                sp_rd_en_d = 1'b1;
                sp_addr_d  = addr_arr_s[win_s];
                sp_d_d     = data_arr_s[win_s];
            end
            OP_WRITE: begin
                sp_wr_en_d = 1'b1;
                sp_addr_d  = addr_arr_s[win_s];
                sp_d_d     = data_arr_s[win_s];
            end
            default: begin
                sp_rd_en_d = 1'b0;
                sp_wr_en_d = 1'b0;
            end
        endcase

        if (found_s) begin
            rr_ptr_d = win_s + ID_WIDTH'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        push_s = (op_s == OP_READ);
        pop_s  = sp_valid & ~fifo_empty_s;
        case ({push_s, pop_s})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Return path: route the returning word to the FIFO head's requester;
    // a return with no read in flight is dropped.
    always_comb begin
        req_valid_d = '0;
        req_q_d     = req_q_q;
        if (pop_s) begin
            req_valid_d[head_id_s] = 1'b1;
            req_q_d                = sp_q;
        end else begin
            req_q_d = req_q_q;
        end
    end

    // Hold scratch_pad returns while the next owner cannot take data.
    always_comb begin
        sp_stall = rst & ~fifo_empty_s & req_stall[head_id_s];
    end

    scratch_pad_port_arbiter_id_fifo #(
        .ID_WIDTH (ID_WIDTH),
        .DEPTH    (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .push_id (win_s),
        .pop     (pop_s),
        .head_id (head_id_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s)
    );

    // Arbiter, issue and return registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            sp_rd_en_q    <= 1'b0;
            sp_wr_en_q    <= 1'b0;
            sp_addr_q     <= '0;
            sp_d_q        <= '0;
            req_valid_q   <= '0;
            req_q_q       <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            sp_rd_en_q    <= sp_rd_en_d;
            sp_wr_en_q    <= sp_wr_en_d;
            sp_addr_q     <= sp_addr_d;
            sp_d_q        <= sp_d_d;
            req_valid_q   <= req_valid_d;
            req_q_q       <= req_q_d;
        end
    end

    // Registered outputs.
    always_comb begin
        sp_rd_en  = sp_rd_en_q;
        sp_wr_en  = sp_wr_en_q;
        sp_addr   = sp_addr_q;
        sp_d      = sp_d_q;
        req_valid = req_valid_q;
        req_q     = req_q_q;
    end

endmodule

// File: tb/tb_scratch_pad_port_arbiter.sv
// Directed self-checking bench for scratch_pad_port_arbiter (4 requesters,
// 64-bit data, 12-bit address, 32 outstanding reads).
module tb_scratch_pad_port_arbiter;

    localparam int R  = 4;
    localparam int W  = 64;
    localparam int AW = 12;

    logic            clk;
    logic            rst;
    logic [0:R-1]    req_rd_en;
    logic [0:R-1]    req_wr_en;
    logic [AW*R-1:0] req_addr;
    logic [W*R-1:0]  req_d;
    logic [0:R-1]    req_grant;
    logic [W-1:0]    req_q;
    logic [0:R-1]    req_valid;
    logic [0:R-1]    req_stall;
    logic            sp_rd_en;
    logic            sp_wr_en;
    logic [AW-1:0]   sp_addr;
    logic [W-1:0]    sp_d;
    logic            sp_full;
    logic [W-1:0]    sp_q;
    logic            sp_valid;
    logic            sp_stall;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int grant_cnt;

    scratch_pad_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_rd_en (req_rd_en),
        .req_wr_en (req_wr_en),
        .req_addr  (req_addr),
        .req_d     (req_d),
        .req_grant (req_grant),
        .req_q     (req_q),
        .req_valid (req_valid),
        .req_stall (req_stall),
        .sp_rd_en  (sp_rd_en),
        .sp_wr_en  (sp_wr_en),
        .sp_addr   (sp_addr),
        .sp_d      (sp_d),
        .sp_full   (sp_full),
        .sp_q      (sp_q),
        .sp_valid  (sp_valid),
        .sp_stall  (sp_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:R-1] oh(input int i);
        logic [0:R-1] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        req_rd_en = 4'b1111;
        req_wr_en = 4'b0000;
        req_stall = 4'b0000;
        sp_full   = 1'b0;
        sp_q      = 64'h0;
        sp_valid  = 1'b0;
        for (int i = 0; i < R; i++) begin
            req_addr[(R-1-i)*AW +: AW] = 12'h100 + 12'(i);
            req_d[(R-1-i)*W +: W]      = 64'hD0 + 64'(i);
        end

        // reset state
        step();
        step();
        @(negedge clk);
        check_val("rst_grant", 64'(req_grant), 64'h0);
        check_val("rst_rd_en", 64'(sp_rd_en), 64'h0);
        check_val("rst_wr_en", 64'(sp_wr_en), 64'h0);
        check_val("rst_addr", 64'(sp_addr), 64'h0);
        check_val("rst_valid", 64'(req_valid), 64'h0);
        check_val("rst_q", req_q, 64'h0);
        check_val("rst_stall", 64'(sp_stall), 64'h0);
        step();
        rst = 1'b1;

        // round robin: 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val($sformatf("rr_grant%0d", k), 64'(req_grant), 64'(oh(k % R)));
            step();
            check_val($sformatf("rr_rd_en%0d", k), 64'(sp_rd_en), 64'h1);
            check_val($sformatf("rr_addr%0d", k), 64'(sp_addr), 64'h100 + 64'(k % R));
        end
        req_rd_en = 4'b0000;

        // drain first return (id 0); head becomes id 1
        sp_valid = 1'b1;
        sp_q     = 64'h10;
        step();
        sp_valid = 1'b0;
        check_val("drain_valid0", 64'(req_valid), 64'(oh(0)));
        check_val("drain_q0", req_q, 64'h10);

        // stall steering on head id 1
        req_stall = 4'b0100;
        @(negedge clk);
        check_val("stall_head1", 64'(sp_stall), 64'h1);
        req_stall = 4'b0001;
        #1;
        check_val("stall_other", 64'(sp_stall), 64'h0);
        req_stall = 4'b0000;
        step();

        // drain remaining ids 1,2,3,0
        for (int j = 0; j < 4; j++) begin
            sp_valid = 1'b1;
            sp_q     = 64'h11 + 64'(j);
            step();
            check_val($sformatf("drain_valid%0d", j + 1), 64'(req_valid), 64'(oh((j + 1) % R)));
            check_val($sformatf("drain_q%0d", j + 1), req_q, 64'h11 + 64'(j));
        end
        sp_valid  = 1'b0;
        req_stall = 4'b1111;
        @(negedge clk);
        check_val("stall_empty", 64'(sp_stall), 64'h0);
        req_stall = 4'b0000;
        step();

        // return routing: reads by 2, 0, 3 (rr_ptr is 1 here)
        req_rd_en = oh(2);
        @(negedge clk);
        check_val("ret_grant2", 64'(req_grant), 64'(oh(2)));
        step();
        req_rd_en = oh(0);
        @(negedge clk);
        check_val("ret_grant0", 64'(req_grant), 64'(oh(0)));
        step();
        req_rd_en = oh(3);
        @(negedge clk);
        check_val("ret_grant3", 64'(req_grant), 64'(oh(3)));
        step();
        req_rd_en = 4'b0000;
        sp_valid = 1'b1; sp_q = 64'hA;
        step();
        check_val("ret_valid_a", 64'(req_valid), 64'(oh(2)));
        check_val("ret_q_a", req_q, 64'hA);
        sp_q = 64'hB;
        step();
        check_val("ret_valid_b", 64'(req_valid), 64'(oh(0)));
        check_val("ret_q_b", req_q, 64'hB);
        sp_q = 64'hC;
        step();
        check_val("ret_valid_c", 64'(req_valid), 64'(oh(3)));
        check_val("ret_q_c", req_q, 64'hC);
        sp_valid = 1'b0; sp_q = 64'hEE;
        step();
        check_val("ret_idle_valid", 64'(req_valid), 64'h0);
        check_val("ret_hold_q", req_q, 64'hC);

        // backpressure: rr_ptr is 0, requesters 1 and 2 pending
        sp_full   = 1'b1;
        req_rd_en = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val($sformatf("bp_grant%0d", k), 64'(req_grant), 64'h0);
            step();
            check_val($sformatf("bp_rw%0d", k), 64'({sp_rd_en, sp_wr_en}), 64'h0);
        end
        sp_full = 1'b0;
        @(negedge clk);
        check_val("bp_resume1", 64'(req_grant), 64'(oh(1)));
        step();
        @(negedge clk);
        check_val("bp_resume2", 64'(req_grant), 64'(oh(2)));
        step();
        req_rd_en = 4'b0000;
        sp_valid  = 1'b1; sp_q = 64'h21;
        step();
        check_val("bp_ret1", 64'(req_valid), 64'(oh(1)));
        sp_q = 64'h22;
        step();
        check_val("bp_ret2", 64'(req_valid), 64'(oh(2)));
        sp_valid = 1'b0;

        // budget: 32 reads from requester 0 with no returns
        req_rd_en = oh(0);
        grant_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (req_grant == oh(0)) grant_cnt++;
            step();
        end
        check_val("bud_count", 64'(grant_cnt), 64'd32);
        @(negedge clk);
        check_val("bud_rd_block", 64'(req_grant), 64'h0);
        req_wr_en = oh(1);
        #1;
        check_val("bud_wr_grant", 64'(req_grant), 64'(oh(1)));
        step();
        req_wr_en = 4'b0000;
        check_val("bud_wr_issue", 64'({sp_rd_en, sp_wr_en}), 64'h1);
        check_val("bud_wr_data", sp_d, 64'hD1);
        check_val("bud_wr_addr", 64'(sp_addr), 64'h101);
        sp_valid = 1'b1; sp_q = 64'h55;
        @(negedge clk);
        check_val("bud_pop_cycle", 64'(req_grant), 64'h0);
        step();
        sp_valid = 1'b0;
        check_val("bud_pop_valid", 64'(req_valid), 64'(oh(0)));
        @(negedge clk);
        check_val("bud_one_more", 64'(req_grant), 64'(oh(0)));
        step();
        @(negedge clk);
        check_val("bud_full_again", 64'(req_grant), 64'h0);
        req_rd_en = 4'b0000;
        step();

        // reset mid-flight
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_val("mrst_rw", 64'({sp_rd_en, sp_wr_en}), 64'h0);
        check_val("mrst_valid", 64'(req_valid), 64'h0);
        check_val("mrst_q", req_q, 64'h0);
        check_val("mrst_addr", 64'(sp_addr), 64'h0);
        sp_valid = 1'b1; sp_q = 64'h77;
        step();
        sp_valid = 1'b0;
        check_val("mrst_drop_valid", 64'(req_valid), 64'h0);
        check_val("mrst_drop_q", req_q, 64'h0);
        req_rd_en = 4'b1111;
        @(negedge clk);
        check_val("mrst_rr0", 64'(req_grant), 64'(oh(0)));
        step();
        req_rd_en = oh(2);
        req_wr_en = oh(2);
        @(negedge clk);
        check_val("rw_grant", 64'(req_grant), 64'(oh(2)));
        step();
        req_rd_en = 4'b0000;
        req_wr_en = 4'b0000;
        check_val("rw_issue", 64'({sp_rd_en, sp_wr_en}), 64'h1);
        sp_valid = 1'b1; sp_q = 64'h99;
        step();
        check_val("rw_ret0", 64'(req_valid), 64'(oh(0)));
        step();
        sp_valid = 1'b0;
        check_val("rw_no_push", 64'(req_valid), 64'h0);
        check_val("rw_q_hold", req_q, 64'h99);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
